// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the memory bus initiator: state encodings, length
// normalisation and the debug view of the sequencer.
package mem_bus_master_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_ACCESS  = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  localparam int         MAX_LEN_DEFAULT = 3;
  localparam int         WAIT_W          = 4;
  localparam logic [1:0] LEN_ONE         = 2'd1;

  typedef struct packed {
    logic [2:0] state;
    logic [1:0] index;
  } dbg_t;

  // A zero length means one byte; anything above the burst limit is clipped.
  function automatic logic [1:0] norm_len(input logic [1:0] len, input int max_len);
    logic [1:0] l;
    l = (len == 2'd0) ? LEN_ONE : len;
    if (int'(l) > max_len) l = 2'(max_len);
    return l;
  endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// Request/response and memory-side signal bundle for mem_bus_master.
// Handshake: a request transfers on a rising edge where req_valid & req_ready;
// a response transfers on a rising edge where rsp_valid & rsp_ready; valid is
// held with stable payload until its transfer edge.
interface mem_bus_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_LEN    = 3
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_write;
  logic [7:0]              req_wdata;
  logic [1:0]              req_len;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [8*MAX_LEN-1:0]    rsp_data;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [7:0]              mem_wdata;
  logic [7:0]              mem_rdata;
  logic                    mem_write;
  logic                    mem_strobe;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_len, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_data, mem_addr, mem_wdata, mem_write, mem_strobe
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_len, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, mem_addr, mem_wdata, mem_write, mem_strobe
  );
endinterface

// File: rtl/mem_bus_master_wait_counter.sv
// Loadable down-counter used to time the WAIT state; o_done is high at zero.
module mem_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_en,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/mem_bus_master.sv
// Memory bus initiator: sequences strobe/write/addr toward a registered
// responder and assembles multi-byte reads. Optional counters: MEM_BUS_MASTER_STATS_EN.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int MAX_LEN     = MAX_LEN_DEFAULT,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_bus_master_if.master        bus,
`ifdef MEM_BUS_MASTER_STATS_EN
  output logic [15:0]             stat_reads,
  output logic [15:0]             stat_writes,
`endif
  output dbg_t                    o_dbg
);

  localparam logic [2:0]        FIRST_STATE = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
  localparam logic [WAIT_W-1:0] WAIT_LOAD   = WAIT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  logic [2:0]              r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_write;
  logic [7:0]              r_wdata;
  logic [1:0]              r_len;
  logic [1:0]              r_index;
  logic [8*MAX_LEN-1:0]    r_rsp_data;

  logic w_accept;
  logic w_more;
  logic w_wait_load;
  logic w_wait_done;
  logic w_rsp_done;

  assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
  assign w_more      = ({1'b0, r_index} + 3'd1) < {1'b0, r_len};
  assign w_wait_load = w_accept || ((r_state == ST_CAPTURE) && w_more);
  assign w_rsp_done  = (r_state == ST_RESP) && bus.rsp_ready;

  mem_wait_counter #(
    .WIDTH(WAIT_W)
  ) u_wait (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_wait_load),
    .i_value(WAIT_LOAD),
    .i_en   (r_state == ST_WAIT),
    .o_done (w_wait_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_len      <= LEN_ONE;
      r_index    <= '0;
      r_rsp_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_addr     <= bus.req_addr;
            r_write    <= bus.req_write;
            r_wdata    <= bus.req_wdata;
            // Writes are always a single byte regardless of req_len.
            r_len      <= bus.req_write ? LEN_ONE : norm_len(bus.req_len, MAX_LEN);
            r_index    <= '0;
            r_rsp_data <= '0;
            r_state    <= FIRST_STATE;
          end
        end
        ST_WAIT: begin
          if (w_wait_done) r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_rsp_data[8*r_index +: 8] <= bus.mem_rdata;
          if (w_more) begin
            r_index <= r_index + 2'd1;
            r_addr  <= r_addr + ADDR_WIDTH'(1);
            r_state <= FIRST_STATE;
          end else begin
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.rsp_valid  = (r_state == ST_RESP);
  assign bus.rsp_data   = r_rsp_data;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.mem_strobe = (r_state == ST_ACCESS);
  assign bus.mem_write  = (r_state == ST_ACCESS) && r_write;

  assign o_dbg.state = r_state;
  assign o_dbg.index = r_index;

`ifdef MEM_BUS_MASTER_STATS_EN
  logic [15:0] r_stat_reads;
  logic [15:0] r_stat_writes;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_reads  <= '0;
      r_stat_writes <= '0;
    end else if (w_rsp_done) begin
      if (r_write) begin
        if (r_stat_writes != 16'hFFFF) r_stat_writes <= r_stat_writes + 16'd1;
      end else begin
        if (r_stat_reads != 16'hFFFF) r_stat_reads <= r_stat_reads + 16'd1;
      end
    end
  end

  assign stat_reads  = r_stat_reads;
  assign stat_writes = r_stat_writes;
`else
  logic w_unused_rsp_done;
  assign w_unused_rsp_done = w_rsp_done;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: two instances (0 and 2 wait states) behind a
// select mux, a RAM responder, and a byte-array reference model.
module tb_mem_bus_master;
  import mem_bus_master_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];

  logic        sel;
  logic        req_valid_d;
  logic [15:0] req_addr_d;
  logic        req_write_d;
  logic [7:0]  req_wdata_d;
  logic [1:0]  req_len_d;
  logic        rsp_ready_d;
  logic [7:0]  rdata0, rdata1;
  dbg_t        dbg0, dbg1;
  int          n_reads, n_writes;

  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];

  mem_bus_master_if #(.ADDR_WIDTH(16), .MAX_LEN(3)) b0 ();
  mem_bus_master_if #(.ADDR_WIDTH(16), .MAX_LEN(3)) b1 ();

`ifdef MEM_BUS_MASTER_STATS_EN
  logic [15:0] s0_reads, s0_writes, s1_reads, s1_writes;
`endif

  mem_bus_master #(.ADDR_WIDTH(16), .MAX_LEN(3), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0),
`ifdef MEM_BUS_MASTER_STATS_EN
    .stat_reads(s0_reads), .stat_writes(s0_writes),
`endif
    .o_dbg(dbg0)
  );

  mem_bus_master #(.ADDR_WIDTH(16), .MAX_LEN(3), .WAIT_STATES(2)) dut1 (
    .clk(clk), .reset(reset), .bus(b1),
`ifdef MEM_BUS_MASTER_STATS_EN
    .stat_reads(s1_reads), .stat_writes(s1_writes),
`endif
    .o_dbg(dbg1)
  );

  assign b0.req_valid = req_valid_d & ~sel;
  assign b1.req_valid = req_valid_d & sel;
  assign b0.rsp_ready = rsp_ready_d & ~sel;
  assign b1.rsp_ready = rsp_ready_d & sel;
  assign b0.req_addr  = req_addr_d;
  assign b1.req_addr  = req_addr_d;
  assign b0.req_write = req_write_d;
  assign b1.req_write = req_write_d;
  assign b0.req_wdata = req_wdata_d;
  assign b1.req_wdata = req_wdata_d;
  assign b0.req_len   = req_len_d;
  assign b1.req_len   = req_len_d;
  assign b0.mem_rdata = rdata0;
  assign b1.mem_rdata = rdata1;

  wire        m_req_ready = sel ? b1.req_ready  : b0.req_ready;
  wire        m_rsp_valid = sel ? b1.rsp_valid  : b0.rsp_valid;
  wire [23:0] m_rsp_data  = sel ? b1.rsp_data   : b0.rsp_data;
  wire [15:0] m_mem_addr  = sel ? b1.mem_addr   : b0.mem_addr;
  wire [7:0]  m_mem_wdata = sel ? b1.mem_wdata  : b0.mem_wdata;
  wire        m_strobe    = sel ? b1.mem_strobe : b0.mem_strobe;
  wire        m_write     = sel ? b1.mem_write  : b0.mem_write;

  // RAM responder: dataOut registered on the strobe edge, write echoes dataIn.
  always @(posedge clk) begin
    if (b0.mem_strobe) begin
      if (b0.mem_write) begin
        ram[b0.mem_addr] <= b0.mem_wdata;
        rdata0 <= b0.mem_wdata;
      end else begin
        rdata0 <= ram[b0.mem_addr];
      end
    end
    if (b1.mem_strobe) begin
      if (b1.mem_write) begin
        ram[b1.mem_addr] <= b1.mem_wdata;
        rdata1 <= b1.mem_wdata;
      end else begin
        rdata1 <= ram[b1.mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_txn(input logic [15:0] addr, input logic wr, input logic [7:0] wdata,
                        input logic [1:0] len);
    int eff, ws, per, off, nstb, lat, addr_bad, busy_bad, hold, hold_bad;
    logic [23:0] exp, exp_pop;
    logic [15:0] a;
    eff = wr ? 1 : ((len == 2'd0) ? 1 : int'(len));
    ws  = sel ? 2 : 0;
    per = 2 + ws;
    exp = '0;
    for (int i = 0; i < eff; i++) begin
      a = addr + 16'(i);
      exp[8*i +: 8] = wr ? wdata : ref_mem[a];
    end
    if (wr) ref_mem[addr] = wdata;
    exp_q.push_back(exp);

    @(negedge clk);
    req_addr_d = addr; req_write_d = wr; req_wdata_d = wdata; req_len_d = len;
    req_valid_d = 1'b1;
    off = 0;
    while (m_req_ready !== 1'b1 && off < 50) begin
      @(negedge clk);
      off++;
    end
    check("accept_ready", m_req_ready, 1);
    @(posedge clk);
    #1;
    req_valid_d = 1'b0;
    req_addr_d  = 16'($urandom);
    req_wdata_d = 8'($urandom);
    req_len_d   = 2'($urandom);

    @(negedge clk);
    off = 0; nstb = 0; lat = -1; addr_bad = 0; busy_bad = 0;
    while (off < 200) begin
      if (m_rsp_valid === 1'b1) begin
        lat = off;
        break;
      end
      if (m_strobe === 1'b1) begin
        check("strobe_cycle", off, nstb * per + ws);
        check("strobe_addr", m_mem_addr, 32'(16'(addr + 16'(nstb))));
        check("strobe_write", m_write, wr);
        if (wr) check("strobe_wdata", m_mem_wdata, wdata);
        nstb++;
      end else if (m_write !== 1'b0) begin
        busy_bad++;
      end
      if (m_mem_addr !== 16'(addr + 16'(off / per))) addr_bad++;
      if (m_req_ready !== 1'b0) busy_bad++;
      off++;
      @(negedge clk);
    end
    check("latency", lat, eff * per);
    check("strobe_count", nstb, eff);
    check("addr_stable", addr_bad, 0);
    check("busy_flags", busy_bad, 0);
    exp_pop = exp_q.pop_front();
    check("rsp_data", m_rsp_data, exp_pop);

    // Hold off the response while a competing request is offered.
    hold = $urandom_range(0, 5);
    hold_bad = 0;
    req_write_d = 1'b1;
    req_valid_d = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (m_rsp_valid !== 1'b1 || m_rsp_data !== exp_pop || m_req_ready !== 1'b0 ||
          m_strobe !== 1'b0) hold_bad++;
    end
    check("resp_hold", hold_bad, 0);
    rsp_ready_d = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_d = 1'b0;
    req_valid_d = 1'b0;
    if (!sel) begin
      if (wr) n_writes++;
      else n_reads++;
    end
    @(negedge clk);
    check("post_rsp_valid", m_rsp_valid, 0);
    check("post_req_ready", m_req_ready, 1);
  endtask

  task automatic rand_txn();
    logic [15:0] a;
    a = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + 16'($urandom_range(0, 1))) : 16'($urandom);
    do_txn(a, ($urandom_range(0, 3) == 0), 8'($urandom), 2'($urandom_range(0, 3)));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'(i * 13 + (i >> 8) * 7 + 5);
      ref_mem[i] = 8'(i * 13 + (i >> 8) * 7 + 5);
    end
    sel = 1'b0;
    reset = 1'b1;
    req_valid_d = 1'b0; req_addr_d = '0; req_write_d = 1'b0;
    req_wdata_d = '0; req_len_d = '0; rsp_ready_d = 1'b0;
    n_reads = 0; n_writes = 0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", b0.req_ready, 1);
    check("rst_rsp_valid", b0.rsp_valid, 0);
    check("rst_rsp_data", b0.rsp_data, 0);
    check("rst_strobe", b0.mem_strobe, 0);
    check("rst_write", b0.mem_write, 0);
    check("rst_addr", b0.mem_addr, 0);
    check("rst_wdata", b0.mem_wdata, 0);
    check("rst_dbg_state", dbg0.state, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_req_ready", b0.req_ready, 1);

    // Directed: burst read, write/readback, wrap at top of memory.
    do_txn(16'h0100, 1'b1, 8'h31, 2'd0);
    do_txn(16'h0101, 1'b1, 8'h42, 2'd0);
    do_txn(16'h0102, 1'b1, 8'h53, 2'd3);
    do_txn(16'h0100, 1'b0, 8'h00, 2'd3);
    check("plan_burst", b0.rsp_data, 32'h534231);
    do_txn(16'h07FF, 1'b1, 8'hA5, 2'd2);
    check("plan_write_echo", b0.rsp_data, 32'h0000A5);
    do_txn(16'h07FF, 1'b0, 8'h00, 2'd1);
    check("plan_readback", b0.rsp_data, 32'h0000A5);
    do_txn(16'hFFFF, 1'b0, 8'h00, 2'd2);
    for (int n = 0; n < 30; n++) rand_txn();

    // Wait-state instance.
    @(negedge clk);
    sel = 1'b1;
    do_txn(16'h0100, 1'b0, 8'h00, 2'd1);
    check("plan_ws_read", b1.rsp_data, 32'h31);
    for (int n = 0; n < 12; n++) rand_txn();
    @(negedge clk);
    sel = 1'b0;

    // Reset during CAPTURE of byte 1 of a 3-byte read.
    @(negedge clk);
    req_addr_d = 16'h0100; req_write_d = 1'b0; req_len_d = 2'd3; req_valid_d = 1'b1;
    @(posedge clk);
    #1;
    req_valid_d = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_rst_dbg_capture", dbg0.state, 3);
    reset = 1'b1;
    n_reads = 0; n_writes = 0;
    #1;
    check("arst_strobe", b0.mem_strobe, 0);
    check("arst_rsp_valid", b0.rsp_valid, 0);
    check("arst_rsp_data", b0.rsp_data, 0);
    check("arst_req_ready", b0.req_ready, 1);
`ifdef MEM_BUS_MASTER_STATS_EN
    check("arst_stat_reads", s0_reads, 0);
    check("arst_stat_writes", s0_writes, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rel_req_ready", b0.req_ready, 1);
    do_txn(16'h0100, 1'b0, 8'h00, 2'd1);
    do_txn(16'h2000, 1'b1, 8'h5A, 2'd0);
    do_txn(16'h2000, 1'b0, 8'h00, 2'd3);
`ifdef MEM_BUS_MASTER_STATS_EN
    check("stat_reads", s0_reads, n_reads);
    check("stat_writes", s0_writes, n_writes);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
